// File: rtl/register_bank_reader.sv
// register_bank_reader
//
// Eight-entry, 32-bit register bank with a single write port and a read-out
// engine that streams a contiguous, wrapping run of entries to a downstream
// consumer over a valid/ready handshake, one word per cycle.
//
// Ports:
//   clk       rising-edge clock
//   reset     synchronous, active-high reset (clears bank and engine)
//   we        bank write enable
//   wr_addr   bank write address
//   wr_data   bank write data
//   start     request a read-out run (only honoured while idle)
//   first     index of the first entry of the run
//   count     number of entries in the run (0..8, larger values clamp to 8)
//   rd_data   word currently presented to the consumer
//   rd_index  bank index of rd_data
//   rd_valid  rd_data/rd_index are valid
//   rd_ready  consumer accepts the presented word
//   busy      engine is not idle
//   done      one-cycle pulse marking the end of a run

module register_bank_reader (
  input  logic        clk,
  input  logic        reset,
  input  logic        we,
  input  logic [2:0]  wr_addr,
  input  logic [31:0] wr_data,
  input  logic        start,
  input  logic [2:0]  first,
  input  logic [3:0]  count,
  output logic [31:0] rd_data,
  output logic [2:0]  rd_index,
  output logic        rd_valid,
  input  logic        rd_ready,
  output logic        busy,
  output logic        done
);

  localparam int DEPTH = 8;
  localparam int AW    = 3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEND,
    ST_DONE
  } state_t;

  state_t          state;
  logic [31:0]     mem [DEPTH];
  logic [AW-1:0]   ptr;
  logic [AW-1:0]   next_ptr;
  logic [3:0]      remain;
  logic [31:0]     first_word;
  logic [31:0]     next_word;

  // Word fetch for the two load points (run start and handshake). A write
  // landing on the same entry in the same cycle is forwarded so the consumer
  // sees the freshest value rather than the one about to be overwritten.
  // The 3-bit pointer increment wraps 7 -> 0 naturally.
  always_comb begin
    next_ptr   = ptr + 3'd1;
    first_word = (we && (wr_addr == first))    ? wr_data : mem[first];
    next_word  = (we && (wr_addr == next_ptr)) ? wr_data : mem[next_ptr];
  end

  // Busy covers both the streaming and the done-pulse states.
  assign busy = (state != ST_IDLE);

  // Bank storage and read-out engine. Writes are accepted in every state and
  // never disturb a word already presented, because rd_data is a register
  // that only reloads at the start of a run or on a handshake. done is raised
  // on the same edge that enters ST_DONE, so it is high exactly while the
  // engine sits in that state.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      state    <= ST_IDLE;
      ptr      <= '0;
      remain   <= '0;
      rd_data  <= '0;
      rd_index <= '0;
      rd_valid <= 1'b0;
      done     <= 1'b0;
    end else begin
      if (we) begin
        mem[wr_addr] <= wr_data;
      end
      done <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (start) begin
            if (count != 4'd0) begin
              ptr      <= first;
              remain   <= (count > 4'd8) ? 4'd8 : count;
              rd_data  <= first_word;
              rd_index <= first;
              rd_valid <= 1'b1;
              state    <= ST_SEND;
            end else begin
              done  <= 1'b1;
              state <= ST_DONE;
            end
          end
        end

        ST_SEND: begin
          if (rd_valid && rd_ready) begin
            if (remain == 4'd1) begin
              rd_valid <= 1'b0;
              done     <= 1'b1;
              state    <= ST_DONE;
            end else begin
              ptr      <= next_ptr;
              remain   <= remain - 4'd1;
              rd_data  <= next_word;
              rd_index <= next_ptr;
            end
          end
        end

        ST_DONE: begin
          state <= ST_IDLE;
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_register_bank_reader.sv
// tb_register_bank_reader
//
// Self-checking bench for register_bank_reader. A plain array mirrors the
// bank contents; expected word streams are derived from it using the
// modular index arithmetic of a run (entry (first+i) mod 8 for i < min(count,8)).

module tb_register_bank_reader;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        we = 1'b0;
  logic [2:0]  wr_addr = '0;
  logic [31:0] wr_data = '0;
  logic        start = 1'b0;
  logic [2:0]  first = '0;
  logic [3:0]  count = '0;
  logic [31:0] rd_data;
  logic [2:0]  rd_index;
  logic        rd_valid;
  logic        rd_ready = 1'b0;
  logic        busy;
  logic        done;

  int checks = 0;
  int errors = 0;
  int cycle  = 0;

  logic [31:0] model_mem [8];
  logic [31:0] exp_data [$];
  int          exp_idx  [$];
  logic [31:0] obs_data [$];
  int          obs_idx  [$];
  int          obs_cyc  [$];
  int          n_done;
  int          done_cycle;
  int          stable_err;
  bit          timed_out;

  register_bank_reader dut (
    .clk      (clk),
    .reset    (reset),
    .we       (we),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .start    (start),
    .first    (first),
    .count    (count),
    .rd_data  (rd_data),
    .rd_index (rd_index),
    .rd_valid (rd_valid),
    .rd_ready (rd_ready),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  // One clock: the model bank follows the same edge the DUT sees, then the
  // bench returns to the falling edge to sample outputs and drive inputs.
  task automatic tick();
    @(posedge clk);
    if (reset) begin
      for (int i = 0; i < 8; i++) model_mem[i] = '0;
    end else if (we) begin
      model_mem[wr_addr] = wr_data;
    end
    @(negedge clk);
    cycle++;
  endtask

  task automatic write_word(input int addr, input logic [31:0] data);
    we = 1'b1;
    wr_addr = addr[2:0];
    wr_data = data;
    tick();
    we = 1'b0;
  endtask

  task automatic kick(input int f, input int c);
    start = 1'b1;
    first = f[2:0];
    count = c[3:0];
    tick();
    start = 1'b0;
  endtask

  task automatic build_expected(input int f, input int c);
    int n;
    exp_data.delete();
    exp_idx.delete();
    n = (c > 8) ? 8 : c;
    for (int i = 0; i < n; i++) begin
      exp_idx.push_back((f + i) % 8);
      exp_data.push_back(model_mem[(f + i) % 8]);
    end
  endtask

  // Consumer: randomly asserts rd_ready, records accepted words and the
  // cycle they were accepted in, counts done pulses and hold violations.
  task automatic drain(input int ready_pct, input int max_cycles);
    bit          hold;
    logic [31:0] hold_data;
    logic [2:0]  hold_idx;
    obs_data.delete();
    obs_idx.delete();
    obs_cyc.delete();
    n_done = 0;
    done_cycle = -1;
    stable_err = 0;
    timed_out = 1'b1;
    hold = 1'b0;
    hold_data = '0;
    hold_idx = '0;
    for (int c = 0; c < max_cycles; c++) begin
      if (hold && (!rd_valid || rd_data !== hold_data || rd_index !== hold_idx))
        stable_err++;
      if (done) begin
        n_done++;
        done_cycle = c;
        timed_out = 1'b0;
        break;
      end
      rd_ready = ($urandom_range(99) < ready_pct);
      if (rd_valid && rd_ready) begin
        obs_data.push_back(rd_data);
        obs_idx.push_back(int'(rd_index));
        obs_cyc.push_back(c);
      end
      hold = rd_valid && !rd_ready;
      hold_data = rd_data;
      hold_idx = rd_index;
      tick();
    end
    rd_ready = 1'b0;
    tick();
    if (done) n_done++;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    checks++; if (rd_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid got %b exp 0", rd_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got %b exp 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done got %b exp 0", done); end
    checks++; if (rd_data !== 32'h0) begin errors++; $display("[TB] FAIL reset_data got %h exp 0", rd_data); end
    checks++; if (rd_index !== 3'd0) begin errors++; $display("[TB] FAIL reset_index got %0d exp 0", rd_index); end
    reset = 1'b0;
    tick();
    for (int i = 0; i < 8; i++) write_word(i, 32'h1111_1111 * i);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    kick(0, 8);
    drain(100, 40);
    checks++; if (obs_data.size() != 8) begin errors++; $display("[TB] FAIL reset_run_len got %0d exp 8", obs_data.size()); end
    for (int i = 0; i < obs_data.size() && i < 8; i++) begin
      checks++; if (obs_data[i] !== 32'h0 || obs_idx[i] != i) begin errors++; $display("[TB] FAIL reset_run_word%0d got %h@%0d exp 00000000@%0d", i, obs_data[i], obs_idx[i], i); end
    end
    checks++; if (n_done != 1 || timed_out) begin errors++; $display("[TB] FAIL reset_run_done got %0d pulses timeout %0d exp 1 pulse", n_done, timed_out); end
  endtask

  task automatic test_basic_stream();
    for (int i = 0; i < 8; i++) write_word(i, 32'hA000_0000 + i);
    build_expected(2, 3);
    kick(2, 3);
    checks++; if (busy !== 1'b1 || rd_valid !== 1'b1) begin errors++; $display("[TB] FAIL basic_latency got busy %b valid %b exp 1 1", busy, rd_valid); end
    drain(100, 20);
    checks++; if (obs_data.size() != 3) begin errors++; $display("[TB] FAIL basic_len got %0d exp 3", obs_data.size()); end
    for (int i = 0; i < obs_data.size() && i < 3; i++) begin
      checks++; if (obs_data[i] !== (32'hA000_0002 + i) || obs_idx[i] != 2 + i || obs_cyc[i] != i)
        begin errors++; $display("[TB] FAIL basic_word%0d got %h@%0d cyc %0d exp %h@%0d cyc %0d", i, obs_data[i], obs_idx[i], obs_cyc[i], 32'hA000_0002 + i, 2 + i, i); end
    end
    checks++; if (done_cycle != 3 || n_done != 1) begin errors++; $display("[TB] FAIL basic_done got cyc %0d pulses %0d exp cyc 3 pulses 1", done_cycle, n_done); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL basic_idle got busy %b exp 0", busy); end
  endtask

  task automatic test_wrap_clamp();
    build_expected(6, 15);
    kick(6, 15);
    drain(70, 200);
    checks++; if (obs_data.size() != 8) begin errors++; $display("[TB] FAIL wrap_len got %0d exp 8", obs_data.size()); end
    for (int i = 0; i < obs_data.size() && i < 8; i++) begin
      checks++; if (obs_idx[i] != exp_idx[i] || obs_data[i] !== exp_data[i])
        begin errors++; $display("[TB] FAIL wrap_word%0d got %h@%0d exp %h@%0d", i, obs_data[i], obs_idx[i], exp_data[i], exp_idx[i]); end
    end
    checks++; if (n_done != 1 || stable_err != 0 || timed_out) begin errors++; $display("[TB] FAIL wrap_done got pulses %0d holderr %0d timeout %0d exp 1 0 0", n_done, stable_err, timed_out); end
  endtask

  task automatic test_back_pressure();
    int f;
    logic [31:0] exp0;
    f = $urandom_range(7);
    exp0 = model_mem[f];
    rd_ready = 1'b0;
    kick(f, 2);
    for (int k = 0; k < 3; k++) begin
      checks++; if (rd_valid !== 1'b1 || rd_data !== exp0 || rd_index !== f[2:0])
        begin errors++; $display("[TB] FAIL bp_hold%0d got %b %h@%0d exp 1 %h@%0d", k, rd_valid, rd_data, rd_index, exp0, f); end
      we = (k == 0);
      wr_addr = f[2:0];
      wr_data = 32'hDEAD_BEEF;
      tick();
    end
    we = 1'b0;
    checks++; if (rd_valid !== 1'b1 || rd_data !== exp0) begin errors++; $display("[TB] FAIL bp_after_write got %b %h exp 1 %h", rd_valid, rd_data, exp0); end
    rd_ready = 1'b1;
    tick();
    checks++; if (rd_data !== model_mem[(f + 1) % 8] || rd_index !== 3'((f + 1) % 8))
      begin errors++; $display("[TB] FAIL bp_second got %h@%0d exp %h@%0d", rd_data, rd_index, model_mem[(f + 1) % 8], (f + 1) % 8); end
    tick();
    rd_ready = 1'b0;
    checks++; if (done !== 1'b1 || rd_valid !== 1'b0) begin errors++; $display("[TB] FAIL bp_done got done %b valid %b exp 1 0", done, rd_valid); end
    tick();
    checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("[TB] FAIL bp_idle got done %b busy %b exp 0 0", done, busy); end
    checks++; if (model_mem[f] !== 32'hDEAD_BEEF) begin errors++; $display("[TB] FAIL bp_model got %h exp deadbeef", model_mem[f]); end
  endtask

  task automatic test_bypass_busy_start();
    int f;
    bit saw_busy;
    f = $urandom_range(7);
    rd_ready = 1'b0;
    kick(f, 4);
    rd_ready = 1'b1;
    we = 1'b1;
    wr_addr = 3'((f + 1) % 8);
    wr_data = 32'h1234_5678;
    tick();
    we = 1'b0;
    checks++; if (rd_data !== 32'h1234_5678 || rd_index !== 3'((f + 1) % 8))
      begin errors++; $display("[TB] FAIL bypass_word got %h@%0d exp 12345678@%0d", rd_data, rd_index, (f + 1) % 8); end
    start = 1'b1;
    first = 3'((f + 4) % 8);
    count = 4'd3;
    tick();
    start = 1'b0;
    checks++; if (rd_index !== 3'((f + 2) % 8) || rd_data !== model_mem[(f + 2) % 8])
      begin errors++; $display("[TB] FAIL busy_start_word got %h@%0d exp %h@%0d", rd_data, rd_index, model_mem[(f + 2) % 8], (f + 2) % 8); end
    tick();
    checks++; if (rd_index !== 3'((f + 3) % 8) || rd_data !== model_mem[(f + 3) % 8])
      begin errors++; $display("[TB] FAIL bypass_last got %h@%0d exp %h@%0d", rd_data, rd_index, model_mem[(f + 3) % 8], (f + 3) % 8); end
    tick();
    rd_ready = 1'b0;
    checks++; if (done !== 1'b1 || rd_valid !== 1'b0) begin errors++; $display("[TB] FAIL bypass_done got done %b valid %b exp 1 0", done, rd_valid); end
    saw_busy = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      if (busy || rd_valid) saw_busy = 1'b1;
    end
    checks++; if (saw_busy) begin errors++; $display("[TB] FAIL busy_start_queued got busy 1 exp 0"); end
    kick($urandom_range(7), 0);
    checks++; if (done !== 1'b1 || rd_valid !== 1'b0 || busy !== 1'b1)
      begin errors++; $display("[TB] FAIL zero_count got done %b valid %b busy %b exp 1 0 1", done, rd_valid, busy); end
    tick();
    checks++; if (done !== 1'b0 || rd_valid !== 1'b0 || busy !== 1'b0)
      begin errors++; $display("[TB] FAIL zero_count_end got done %b valid %b busy %b exp 0 0 0", done, rd_valid, busy); end
  endtask

  task automatic test_mid_run_reset();
    bit saw_done;
    rd_ready = 1'b1;
    kick($urandom_range(7), 5);
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    rd_ready = 1'b0;
    checks++; if (rd_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0)
      begin errors++; $display("[TB] FAIL midreset got valid %b busy %b done %b exp 0 0 0", rd_valid, busy, done); end
    saw_done = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      if (done || busy) saw_done = 1'b1;
    end
    checks++; if (saw_done) begin errors++; $display("[TB] FAIL midreset_after got done/busy 1 exp 0"); end
  endtask

  task automatic test_random_runs();
    int f;
    int c;
    int pct;
    for (int r = 0; r < 10; r++) begin
      for (int w = 0; w < 3; w++) write_word($urandom_range(7), $urandom);
      f = $urandom_range(7);
      c = $urandom_range(15);
      pct = $urandom_range(30, 100);
      build_expected(f, c);
      kick(f, c);
      drain(pct, 300);
      checks++; if (obs_data.size() != exp_data.size())
        begin errors++; $display("[TB] FAIL rand%0d_len got %0d exp %0d", r, obs_data.size(), exp_data.size()); end
      for (int i = 0; i < obs_data.size() && i < exp_data.size(); i++) begin
        checks++; if (obs_data[i] !== exp_data[i] || obs_idx[i] != exp_idx[i])
          begin errors++; $display("[TB] FAIL rand%0d_word%0d got %h@%0d exp %h@%0d", r, i, obs_data[i], obs_idx[i], exp_data[i], exp_idx[i]); end
      end
      checks++; if (n_done != 1 || stable_err != 0 || timed_out || busy !== 1'b0)
        begin errors++; $display("[TB] FAIL rand%0d_end got pulses %0d holderr %0d timeout %0d busy %b exp 1 0 0 0", r, n_done, stable_err, timed_out, busy); end
    end
  endtask

  // Scenarios run back to back; each leaves the engine idle for the next.
  initial begin
    for (int i = 0; i < 8; i++) model_mem[i] = '0;
    @(negedge clk);
    test_reset();
    test_basic_stream();
    test_wrap_clamp();
    test_back_pressure();
    test_bypass_busy_start();
    test_mid_run_reset();
    test_random_runs();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
